// File: rtl/mem_load_unit_pkg.sv
// Shared memory-access definitions: access-length codes, load FSM states,
// captured-request payload. The store-side mask imports the same codes.
package mem_load_unit_pkg;

    localparam int unsigned DATA_W = 32;

    // Access length encoding shared with the store mask
    localparam logic [1:0] LEN_WORD  = 2'd0;
    localparam logic [1:0] LEN_HALF  = 2'd1;
    localparam logic [1:0] LEN_BYTE  = 2'd2;
    localparam logic [1:0] LEN_WORD3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } load_state_e;

    // Request fields held for the whole transaction
    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] len;
        logic       zext;
    } load_req_t;

    // True when the low address bits are not aligned to the access size
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] offset);
        logic mis;
        case (len)
            LEN_HALF: mis = offset[0];
            LEN_BYTE: mis = 1'b0;
            default:  mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_unit_load_extract.sv
// Combinational little-endian lane select plus sign/zero extension.
module load_extract
    import mem_load_unit_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [1:0]        len,
    input  logic              zext,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane and extend it to 32 bits
    always_comb begin
        byte_lane = 8'h00;
        half_lane = 16'h0000;
        result    = word;
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (len)
            LEN_BYTE: result = zext ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            LEN_HALF: result = zext ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: accepts a MEM-stage load, issues one word-aligned read to the
// synchronous data memory, extracts/extends the result and hands it to
// write-back. Optional macro MEM_LOAD_MISALIGN_TRAP_EN turns misaligned
// half/word loads into an immediate error response without a memory read.
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_len,
    input  logic              req_unsigned,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    load_state_e       state;
    load_req_t         req_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] extracted_c;
    logic              misalign_c;

    load_extract u_extract (
        .word   (mem_rd_data),
        .offset (req_q.offset),
        .len    (req_q.len),
        .zext   (req_q.zext),
        .result (extracted_c)
    );

    // Misalignment trap decision for the incoming request
    always_comb begin
        misalign_c = 1'b0;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
        misalign_c = is_misaligned(req_len, req_addr[1:0]);
`endif
    end

    // Load FSM with registered handshake, memory and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            cnt        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            mem_rd_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{offset: req_addr[1:0], len: req_len, zext: req_unsigned};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (misalign_c) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                ST_ISSUE: begin
                    // Read strobe is out this cycle; any response now is stale
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    if (mem_rd_valid) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= extracted_c;
                        resp_err   <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit (TIMEOUT_CYCLES=4). Stimulus pushes the
// expected response; an independent monitor pops on every handshake.
module tb_mem_load_unit;

    localparam int unsigned TMO = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_len = '0;
    logic        req_unsigned = 1'b0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_valid = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    mem_load_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_unsigned (req_unsigned),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got data 0x%08h err %0b, none expected", resp_data, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_data"}, resp_data, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    // Issue one load; dly<0 means the memory never answers (timeout)
    task automatic do_load(input logic [31:0] addr, input logic [1:0] len, input logic uns,
                           input logic [31:0] word, input int dly,
                           input logic [31:0] exp_d, input logic exp_e, input logic spur);
        exp_t e;
        int   n;
        e.data = exp_d;
        e.err  = exp_e;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = addr; req_len = len; req_unsigned = uns;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin n++; @(negedge clk); end
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_len = 2'd2; req_unsigned = ~uns;
        if (spur) begin mem_rd_valid = 1'b1; mem_rd_data = 32'hBAD0_BAD0; end
        @(negedge clk);
        chk("issue_rd_en", 32'(mem_rd_en), 32'd1);
        chk("issue_addr", mem_addr, {addr[31:2], 2'b00});
        chk("issue_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        if (dly == 0) begin mem_rd_valid = 1'b1; mem_rd_data = word; end
        @(negedge clk);
        chk("wait_rd_en_low", 32'(mem_rd_en), 32'd0);
        if (dly > 0) begin
            repeat (dly) @(posedge clk);
            #1; mem_rd_valid = 1'b1; mem_rd_data = word;
        end else if (dly < 0) begin
            repeat (TMO - 1) @(posedge clk);
            @(negedge clk);
            chk("tmo_not_early", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("resp_latency", 32'(resp_valid), 32'd1);
    endtask

    task automatic finish_txn();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin n++; @(negedge clk); end
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Byte/half extraction vectors on word 0x80FF7F01
        do_load(32'h0000_1003, 2'd2, 1'b0, 32'h80FF_7F01, 0, 32'hFFFF_FF80, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_1002, 2'd1, 1'b1, 32'h80FF_7F01, 0, 32'h0000_80FF, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_1002, 2'd1, 1'b0, 32'h80FF_7F01, 0, 32'hFFFF_80FF, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_2001, 2'd2, 1'b1, 32'h80FF_7F01, 1, 32'h0000_007F, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_2002, 2'd2, 1'b0, 32'h80FF_7F01, 0, 32'hFFFF_FFFF, 1'b0, 1'b1); finish_txn();
        do_load(32'h0000_2000, 2'd2, 1'b1, 32'h80FF_7F01, 2, 32'h0000_0001, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_2000, 2'd1, 1'b0, 32'h80FF_7F01, 0, 32'h0000_7F01, 1'b0, 1'b0); finish_txn();
        // Word loads, len 3 and len 0; unsigned flag ignored
        do_load(32'h0000_0100, 2'd3, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b1); finish_txn();
        do_load(32'h0000_0204, 2'd0, 1'b1, 32'h8765_4321, 0, 32'h8765_4321, 1'b0, 1'b0); finish_txn();
        // Response on the last permitted wait cycle still succeeds
        do_load(32'h0000_0300, 2'd0, 1'b0, 32'h1234_5678, TMO - 1, 32'h1234_5678, 1'b0, 1'b0); finish_txn();

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
        begin
            exp_t e;
            e.data = 32'h0; e.err = 1'b1;
            exp_q.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = 32'h0000_0102; req_len = 2'd0; req_unsigned = 1'b0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            chk("trap_no_rd_en", 32'(mem_rd_en), 32'd0);
            chk("trap_resp_valid", 32'(resp_valid), 32'd1);
            finish_txn();
        end
`else
        // Misaligned addresses are forced aligned
        do_load(32'h0000_0102, 2'd0, 1'b0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0, 1'b0); finish_txn();
        do_load(32'h0000_2001, 2'd1, 1'b1, 32'h80FF_7F01, 0, 32'h0000_7F01, 1'b0, 1'b0); finish_txn();
`endif

        // Backpressure: response must hold for 5 cycles
        resp_ready = 1'b0;
        do_load(32'h0000_0400, 2'd1, 1'b0, 32'h0000_9ABC, 0, 32'hFFFF_9ABC, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", resp_data, 32'hFFFF_9ABC);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Timeout, then late valid during RESP and during IDLE
        resp_ready = 1'b0;
        do_load(32'h0000_0500, 2'd0, 1'b0, 32'h0, -1, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("late_resp_data", resp_data, 32'h0);
        chk("late_resp_err", 32'(resp_err), 32'd1);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        finish_txn();
        @(posedge clk); #1;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("late_idle_valid", 32'(resp_valid), 32'd0);
        chk("late_idle_busy", 32'(busy), 32'd0);
        do_load(32'h0000_0600, 2'd2, 1'b0, 32'h0000_6000, 0, 32'h0000_0000, 1'b0, 1'b0); finish_txn();

        // Asynchronous reset in the middle of WAIT
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_0700; req_len = 2'd0; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
        do_load(32'h0000_0801, 2'd2, 1'b0, 32'h0000_8000, 0, 32'hFFFF_FF80, 1'b0, 1'b0); finish_txn();

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
